// File: rtl/sal_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sal_fifo_pkg
// Shared helpers for the sal_fifo_ext synchronous FIFO:
//   fifo_flags_t  - bundle of the four registered level flags
//   cnt_width()   - width of an occupancy counter able to hold 0..depth
//   thres_ge()    - "at or above threshold" check used for the almost-full flag
//   thres_le()    - "at or below threshold" check used for the almost-empty flag
// -----------------------------------------------------------------------------
package sal_fifo_pkg;

   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic aempty;
   } fifo_flags_t;

   // An occupancy counter must represent 0..depth inclusive, hence depth+1 codes.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic thres_ge(input int occ, input int thres);
      return (occ >= thres);
   endfunction

   function automatic logic thres_le(input int occ, input int thres);
      return (occ <= thres);
   endfunction

endpackage : sal_fifo_pkg

// File: rtl/sal_fifo_mem.sv
// -----------------------------------------------------------------------------
// sal_fifo_mem
// Storage array for sal_fifo_ext: one synchronous write port and one
// asynchronous read port, no reset. Kept as its own module so it can be
// replaced by an SRAM macro wrapper with the same ports.
// Ports:
//   i_clk    in   clock (write on rising edge)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module sal_fifo_mem #(
   parameter int ADDR_W     = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : sal_fifo_mem

// File: rtl/sal_fifo_ext.sv
// -----------------------------------------------------------------------------
// sal_fifo_ext
// Synchronous FIFO with registered level flags, sticky overflow/underflow
// flags, synchronous flush and an optional prefetch output register.
// Parameters:
//   DEPTH_LG2    log2 of storage depth (1..10)
//   DATA_WIDTH   entry width
//   AFULL_THRES  afull_o when occupancy >= this value
//   AEMPTY_THRES aempty_o when occupancy <= this value
//   OUT_REG      0: rdata_o read combinationally from storage
//                1: rdata_o driven from a prefetch flop
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush_i    in   synchronous discard of all contents (beats wren_i/rden_i)
//   wren_i     in   write request
//   wdata_i    in   write data
//   full_o     out  no free entry
//   afull_o    out  almost full
//   rden_i     in   read request (pop head)
//   rdata_o    out  head entry
//   empty_o    out  no readable entry
//   aempty_o   out  almost empty
//   cnt_o      out  occupancy 0..DEPTH (includes the prefetched entry)
//   clr_err_i  in   clear sticky error flags
//   ovf_o      out  sticky: write attempted while full
//   udf_o      out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sal_fifo_ext
   import sal_fifo_pkg::*;
#(
   parameter int DEPTH_LG2    = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
   parameter int AEMPTY_THRES = 1,
   parameter int OUT_REG      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  full_o,
   output logic                  afull_o,
   input  logic                  rden_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  empty_o,
   output logic                  aempty_o,
   output logic [DEPTH_LG2:0]    cnt_o,
   input  logic                  clr_err_i,
   output logic                  ovf_o,
   output logic                  udf_o
);

   localparam int DEPTH = 1 << DEPTH_LG2;
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = DEPTH_LG2 + 1;

   // Elaboration-time parameter checks
   if ((DEPTH_LG2 < 1) || (DEPTH_LG2 > 10)) begin : g_bad_depth
      $error("sal_fifo_ext: DEPTH_LG2 must be in 1..10");
   end
   if (AFULL_THRES > DEPTH) begin : g_bad_afull
      $error("sal_fifo_ext: AFULL_THRES must not exceed DEPTH");
   end
   if (AEMPTY_THRES >= DEPTH) begin : g_bad_aempty
      $error("sal_fifo_ext: AEMPTY_THRES must be below DEPTH");
   end
   if (CNT_W != PTR_W) begin : g_bad_cntw
      $error("sal_fifo_ext: count width mismatch");
   end

   // State registers
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_full;
   logic                  r_afull;
   logic                  r_empty;
   logic                  r_aempty;
   logic                  r_ovf;
   logic                  r_udf;
   logic                  r_pf_vld;
   logic [DATA_WIDTH-1:0] r_pf_data;

   // Next-state and control wires
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_mem_empty;
   logic                  w_mem_pop;
   logic                  w_pf_load;
   logic                  w_pf_vld_nxt;
   logic [PTR_W-1:0]      w_wptr_nxt;
   logic [PTR_W-1:0]      w_rptr_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   fifo_flags_t           w_flags_nxt;
   logic                  w_ovf_nxt;
   logic                  w_udf_nxt;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   sal_fifo_mem #(
      .ADDR_W     (DEPTH_LG2),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wptr[DEPTH_LG2-1:0]),
      .i_wdata (wdata_i),
      .i_raddr (r_rptr[DEPTH_LG2-1:0]),
      .o_rdata (w_mem_rdata)
   );

   always_comb begin
      w_wr_acc    = wren_i & ~r_full  & ~flush_i;
      w_rd_acc    = rden_i & ~r_empty & ~flush_i;
      w_mem_empty = (r_wptr == r_rptr);

      // With the prefetch register, the storage pointer advances when the flop
      // is refilled: either it is vacant or its entry is being popped now.
      // That refill in the same edge as the pop is what keeps reads bubble-free.
      if (OUT_REG != 0) begin
         w_pf_load = ~flush_i & ~w_mem_empty & (~r_pf_vld | w_rd_acc);
         w_mem_pop = w_pf_load;
      end else begin
         w_pf_load = 1'b0;
         w_mem_pop = w_rd_acc;
      end

      if (flush_i) begin
         w_pf_vld_nxt = 1'b0;
      end else if (w_pf_load) begin
         w_pf_vld_nxt = 1'b1;
      end else if (w_rd_acc) begin
         w_pf_vld_nxt = 1'b0;
      end else begin
         w_pf_vld_nxt = r_pf_vld;
      end

      // Flush collapses the read pointer onto the write pointer; the write
      // pointer itself never needs to move back.
      if (flush_i) begin
         w_wptr_nxt = r_wptr;
         w_rptr_nxt = r_wptr;
         w_cnt_nxt  = '0;
      end else begin
         w_wptr_nxt = r_wptr + {{DEPTH_LG2{1'b0}}, w_wr_acc};
         w_rptr_nxt = r_rptr + {{DEPTH_LG2{1'b0}}, w_mem_pop};
         case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            default: w_cnt_nxt = r_cnt;
         endcase
      end

      w_flags_nxt.full   = (int'(w_cnt_nxt) == DEPTH);
      w_flags_nxt.afull  = thres_ge(int'(w_cnt_nxt), AFULL_THRES);
      w_flags_nxt.aempty = thres_le(int'(w_cnt_nxt), AEMPTY_THRES);
      // In prefetch mode an entry is only readable once it sits in the flop,
      // so empty lags the count by the refill cycle.
      if (OUT_REG != 0) begin
         w_flags_nxt.empty = ~w_pf_vld_nxt;
      end else begin
         w_flags_nxt.empty = (w_cnt_nxt == '0);
      end

      // A new error in the clearing cycle takes precedence over the clear.
      w_ovf_nxt = (wren_i & r_full)  | (r_ovf & ~clr_err_i);
      w_udf_nxt = (rden_i & r_empty) | (r_udf & ~clr_err_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
         r_full    <= 1'b0;
         r_afull   <= 1'b0;
         r_empty   <= 1'b1;
         r_aempty  <= 1'b1;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         r_pf_vld  <= 1'b0;
         r_pf_data <= '0;
      end else begin
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_full    <= w_flags_nxt.full;
         r_afull   <= w_flags_nxt.afull;
         r_empty   <= w_flags_nxt.empty;
         r_aempty  <= w_flags_nxt.aempty;
         r_ovf     <= w_ovf_nxt;
         r_udf     <= w_udf_nxt;
         r_pf_vld  <= w_pf_vld_nxt;
         if (w_pf_load) begin
            r_pf_data <= w_mem_rdata;
         end
      end
   end

   // Without the prefetch flop the unreset storage is masked while empty so
   // that rdata_o is a known zero after reset and between bursts.
   assign rdata_o  = (OUT_REG != 0) ? r_pf_data
                                    : (r_empty ? '0 : w_mem_rdata);
   assign full_o   = r_full;
   assign afull_o  = r_afull;
   assign empty_o  = r_empty;
   assign aempty_o = r_aempty;
   assign cnt_o    = r_cnt;
   assign ovf_o    = r_ovf;
   assign udf_o    = r_udf;

endmodule : sal_fifo_ext

// File: doc/sal_fifo_ext.md
SAL_FIFO_EXT -- requirements
Module: sal_fifo_ext

Interface
REQ-001 The block SHALL have parameter DEPTH_LG2, default 4: storage depth is 2**DEPTH_LG2 entries (DEPTH); legal range 1..10.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: entry width in bits.
REQ-003 The block SHALL have parameter AFULL_THRES, default DEPTH-1: afull_o asserts when occupancy >= this value.
REQ-004 The block SHALL have parameter AEMPTY_THRES, default 1: aempty_o asserts when occupancy <= this value.
REQ-005 The block SHALL have parameter OUT_REG, default 0: 0 means rdata_o is read combinationally from storage; 1 means rdata_o is driven from a prefetch flop.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
clk  in  1  clock, all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous discard of all contents
wren_i  in  1  write request
wdata_i  in  DATA_WIDTH  write data
full_o  out  1  no free entry
afull_o  out  1  almost full
rden_i  in  1  read request (pop head)
rdata_o  out  DATA_WIDTH  head entry
empty_o  out  1  no readable entry
aempty_o  out  1  almost empty
cnt_o  out  DEPTH_LG2+1  occupancy, 0..DEPTH
clr_err_i  in  1  clear sticky error flags
ovf_o  out  1  sticky: write attempted while full
udf_o  out  1  sticky: read attempted while empty

Function
REQ-007 A write SHALL be accepted when wren_i & ~full_o, and a read SHALL be accepted when rden_i & ~empty_o.
REQ-008 A write while full SHALL be dropped with no state change except ovf_o <= 1; a read while empty SHALL leave state unchanged except udf_o <= 1.
REQ-009 Occupancy SHALL change by +1 for an accepted write only, -1 for an accepted read only, and 0 for both or neither; it SHALL never wrap below 0 or above DEPTH.
REQ-010 Simultaneous accepted write and read SHALL be legal at any fill level, including full with rden_i (read accepted, write rejected in the same cycle) and empty with wren_i (write accepted only).
REQ-011 full_o, afull_o, empty_o, aempty_o and cnt_o SHALL be registers computed from next-state occupancy, so they are valid in the cycle after the causing edge.
REQ-012 With OUT_REG=0, a write at edge N into an empty FIFO SHALL deassert empty_o after edge N, and rdata_o SHALL equal that data in the same cycle.
REQ-013 With OUT_REG=1, empty_o SHALL deassert one cycle later than with OUT_REG=0 (after edge N+1), and rdata_o SHALL come from a flop; total capacity SHALL remain DEPTH and cnt_o SHALL include the prefetched entry.
REQ-014 In both modes, rdata_o SHALL present the oldest entry whenever empty_o=0 and SHALL advance to the next entry after each accepted read, with no bubble when more data is stored.
REQ-015 Read and write pointers SHALL be DEPTH_LG2+1 bits and wrap modulo 2*DEPTH.
REQ-016 flush_i SHALL set occupancy to 0, pointers equal, empty_o=1, aempty_o=1, full_o=0 and afull_o=0 after the edge, and SHALL take priority over wren_i and rden_i in the same cycle; ovf_o and udf_o SHALL not be affected by flush_i.
REQ-017 clr_err_i SHALL clear ovf_o and udf_o; a new error in the same cycle SHALL win (flag stays 1).
REQ-018 Elaboration SHALL fail if AFULL_THRES > DEPTH or AEMPTY_THRES >= DEPTH.

Reset
REQ-019 rst_n low SHALL asynchronously force empty_o=1, aempty_o=1, full_o=0, afull_o=0, cnt_o=0, ovf_o=0, udf_o=0, pointers=0 and rdata_o=0 (prefetch flop cleared when OUT_REG=1).
REQ-020 Storage contents SHALL not be reset.
REQ-021 Reset asserted mid-operation SHALL discard all entries, and the first write after deassertion SHALL behave as a write into an empty FIFO.

Structure
REQ-022 Package sal_fifo_pkg SHALL hold the threshold-check function and the clog2-based count-width helper; there SHALL be no module-local duplicates.
REQ-023 Storage SHALL be one sub-module, sal_fifo_mem (1 write port, 1 asynchronous read port, no reset), so that it can later be swapped for an SRAM macro.

Verification
REQ-024 Defaults: write 16 words 0..15 -> full_o=1, cnt_o=16, afull_o=1 from 15; a 17th write -> ovf_o=1, cnt_o stays 16; reading 16 words returns 0..15 in order.
REQ-025 Empty FIFO, rden_i=1 -> udf_o=1, cnt_o=0, and rdata_o unchanged; clr_err_i pulse -> udf_o=0.
REQ-026 Full FIFO, wren_i=rden_i=1 for 1 cycle -> cnt_o=15, full_o=0, written word not stored; half-full with both for 8 cycles -> cnt_o constant at 8.
REQ-027 OUT_REG=1: write 0xA5 at edge N -> empty_o=0 after edge N+1 and rdata_o=0xA5; back-to-back reads of 4 stored words -> 4 consecutive distinct words, no bubble.
REQ-028 cnt_o=5, flush_i together with wren_i and rden_i -> cnt_o=0, empty_o=1; next write of 0x3C -> rdata_o=0x3C.
REQ-029 rst_n asserted asynchronously between edges at cnt_o=7 -> all outputs at reset values before the next edge.
